// File: rtl/tpuv2.sv
// tpuv2: MMIO-mapped DIM x DIM signed matrix-multiply engine.
//
// Computes C = A * B. When clear is requested, C is zeroed first. Otherwise C accumulates
// onto its current contents. Arithmetic wraps at BITS_C bits.
//
// Address map (addr[15:12] selects the region):
//   0x1xxx  A    write loads A row addr[3 +: log2(DIM)]; reads return 0
//   0x2xxx  B    write shifts one row into B (first of DIM writes ends up as row 0)
//   0x3xxx  C    per-word read, read-modify-write per word
//   0x4000  CTRL write: bit0 start, bit1 clear_c, bit2 ack; read: {err, done, busy}
//   0x4008  CTRL cycle count of the last completed run
//   0x4010  CTRL busy-cycle total (TPUV2_PERF_EN only, else 0)
//   0x4018  CTRL completed-run count (TPUV2_PERF_EN only, else 0)
//
// Optional feature macro: TPUV2_PERF_EN (performance counters at 0x4010/0x4018).
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   r_w      1 = write, 0 = read, qualified by req
//   req      one-cycle access strobe
//   addr     byte address
//   dataIn   write data
//   dataOut  registered read data, held until the next read
//   rd_valid pulses the cycle after a read request
//   busy     high while clearing or running
//   done     sticky run-complete flag
module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int RUN_LEN = 3 * DIM - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_w,
    input  logic             req,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             rd_valid,
    output logic             busy,
    output logic             done
);

    localparam int RW    = $clog2(DIM);
    localparam int CW    = DIM * BITS_C / DATAW;      // C words per row
    localparam int CWL   = (CW > 1) ? $clog2(CW) : 0;
    localparam int WW    = (CW > 1) ? CWL : 1;
    localparam int EPW   = DATAW / BITS_C;            // C elements per word
    localparam int STEPW = $clog2(((RUN_LEN > DIM) ? RUN_LEN : DIM) + 1);
    localparam int CNTW  = 32;

    if (DATAW != DIM * BITS_AB) begin : g_chk_dataw
        $error("tpuv2: DATAW must equal DIM*BITS_AB");
    end
    if ((DIM * BITS_C) % DATAW != 0) begin : g_chk_cw
        $error("tpuv2: DIM*BITS_C must be a multiple of DATAW");
    end
    if (BITS_C > 32) begin : g_chk_bitsc
        $error("tpuv2: BITS_C must not exceed 32");
    end

    typedef enum logic [1:0] {StIdle, StClear, StRun, StFin} state_e;

    state_e              state_q, state_d;
    logic [STEPW-1:0]    step_q, step_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNTW-1:0]     cyc_q, cyc_d;
    logic [CNTW-1:0]     cnt_last_q, cnt_last_d;

    logic [BITS_AB-1:0]  a_q [DIM][DIM];
    logic [BITS_AB-1:0]  b_q [DIM][DIM];
    logic [BITS_C-1:0]   c_q [DIM][DIM];

    // Address decode
    logic [3:0]       region;
    logic [11:0]      offset;
    logic             sel_a, sel_b, sel_c, sel_ctrl;
    logic             wr_req, rd_req;
    logic [RW-1:0]    a_row, c_row;
    logic [WW-1:0]    c_word;
    int               c_base;

    assign region   = addr[15:12];
    assign offset   = addr[11:0];
    assign sel_a    = (region == 4'h1);
    assign sel_b    = (region == 4'h2);
    assign sel_c    = (region == 4'h3);
    assign sel_ctrl = (region == 4'h4);
    assign wr_req   = req & r_w;
    assign rd_req   = req & ~r_w;
    assign a_row    = RW'((addr >> 3) & ADDRW'(DIM - 1));
    assign c_word   = WW'((addr >> 3) & ADDRW'(CW - 1));
    assign c_row    = RW'((addr >> (3 + CWL)) & ADDRW'(DIM - 1));
    assign c_base   = int'(c_word) * EPW;

    assign busy = (state_q == StClear) || (state_q == StRun);
    assign done = done_q;

    logic ctrl_wr0, start, start_ok, ack, drop;
    logic a_wr_ok, b_wr_ok, c_wr_ok;

    assign ctrl_wr0 = wr_req & sel_ctrl & (offset == 12'h000);
    assign start    = ctrl_wr0 & dataIn[0];
    assign ack      = ctrl_wr0 & dataIn[2];
    assign start_ok = start & (state_q == StIdle);
    assign drop     = busy & ((wr_req & (sel_a | sel_b | sel_c)) | (rd_req & sel_c) | start);
    assign a_wr_ok  = wr_req & sel_a & ~busy;
    assign b_wr_ok  = wr_req & sel_b & ~busy;
    assign c_wr_ok  = wr_req & sel_c & ~busy;

    // One C row per cycle: row step_q in both CLEAR and the first DIM cycles of RUN.
    logic [RW-1:0]     mac_r;
    logic [BITS_C-1:0] mac_row [DIM];
    int                acc;

    assign mac_r = step_q[RW-1:0];

    always_comb begin
        acc = 0;
        for (int j = 0; j < DIM; j++) begin
            acc = int'($signed(c_q[mac_r][j]));
            for (int k = 0; k < DIM; k++) begin
                acc = acc + int'($signed(a_q[mac_r][k])) * int'($signed(b_q[k][j]));
            end
            mac_row[j] = BITS_C'(acc);
        end
    end

    // Control FSM and status next-state
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        done_d     = done_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        cnt_last_d = cnt_last_q;

        // ack takes effect before a start or error in the same cycle
        if (ack) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (drop) begin
            err_d = 1'b1;
        end
        if (busy && !(&cyc_q)) begin
            cyc_d = cyc_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                step_d = '0;
                if (start_ok) begin
                    done_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = dataIn[1] ? StClear : StRun;
                end
            end
            StClear: begin
                step_d = step_q + 1'b1;
                if (step_q == STEPW'(DIM - 1)) begin
                    step_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                step_d = step_q + 1'b1;
                if (step_q == STEPW'(RUN_LEN - 1)) begin
                    step_d  = '0;
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d     = 1'b1;
                cnt_last_d = cyc_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cyc_q      <= '0;
            cnt_last_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            cnt_last_q <= cnt_last_d;
        end
    end

    // Operand and result storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int k = 0; k < DIM; k++) begin
                    a_q[r][k] <= '0;
                    b_q[r][k] <= '0;
                    c_q[r][k] <= '0;
                end
            end
        end else begin
            if (a_wr_ok) begin
                for (int k = 0; k < DIM; k++) begin
                    a_q[a_row][k] <= dataIn[k*BITS_AB +: BITS_AB];
                end
            end
            if (b_wr_ok) begin
                for (int r = 0; r < DIM - 1; r++) begin
                    for (int k = 0; k < DIM; k++) begin
                        b_q[r][k] <= b_q[r+1][k];
                    end
                end
                for (int k = 0; k < DIM; k++) begin
                    b_q[DIM-1][k] <= dataIn[k*BITS_AB +: BITS_AB];
                end
            end
            if (c_wr_ok) begin
                for (int e = 0; e < EPW; e++) begin
                    c_q[c_row][c_base + e] <= dataIn[e*BITS_C +: BITS_C];
                end
            end
            if (state_q == StClear) begin
                for (int j = 0; j < DIM; j++) begin
                    c_q[mac_r][j] <= '0;
                end
            end
            if ((state_q == StRun) && (step_q < STEPW'(DIM))) begin
                for (int j = 0; j < DIM; j++) begin
                    c_q[mac_r][j] <= mac_row[j];
                end
            end
            // B is consumed by a run: zeros have shifted through by the last RUN cycle.
            if ((state_q == StRun) && (step_q == STEPW'(RUN_LEN - 1))) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int k = 0; k < DIM; k++) begin
                        b_q[r][k] <= '0;
                    end
                end
            end
        end
    end

`ifdef TPUV2_PERF_EN
    logic [31:0] busy_tot_q, runs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_tot_q <= '0;
            runs_q     <= '0;
        end else begin
            if (busy && !(&busy_tot_q)) begin
                busy_tot_q <= busy_tot_q + 1'b1;
            end
            if ((state_q == StFin) && !(&runs_q)) begin
                runs_q <= runs_q + 1'b1;
            end
        end
    end
`endif

    // Read path
    logic [DATAW-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (sel_c && !busy) begin
            for (int e = 0; e < EPW; e++) begin
                rd_data[e*BITS_C +: BITS_C] = c_q[c_row][c_base + e];
            end
        end else if (sel_ctrl) begin
            case (offset)
                12'h000: rd_data[2:0] = {err_q, done_q, busy};
                12'h008: rd_data = DATAW'(cnt_last_q);
`ifdef TPUV2_PERF_EN
                12'h010: rd_data = DATAW'(busy_tot_q);
                12'h018: rd_data = DATAW'(runs_q);
`endif
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                dataOut <= rd_data;
            end
        end
    end

endmodule
